// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if: instruction-fetch request/ready channel between the PC stage and instruction memory.
interface pc_fetch_stage_if #(parameter int WIDTH = 32);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             ready;
  modport master (output req, addr, input ready);
  modport slave  (input req, addr, output ready);
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: PC register and fetch sequencer with a one-entry deferred-redirect buffer.
// Optional MISALIGN_TRAP_EN: misaligned redirects halt the stage and set a sticky misalign_err.
module pc_fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               STEP     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_stage_if.master imem,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             fetch_kill,
  output logic             misalign_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t           state;
  logic [WIDTH-1:0] pc, pend_pc, tgt;
  logic             pend_v, fire;
  assign fire         = imem.req & imem.ready;
  assign imem.addr    = pc;
  assign pc_plus_step = pc + WIDTH'(STEP);
  assign fetch_kill   = fire & (redirect | pend_v);
  assign tgt          = redirect_pc & ~WIDTH'(3);
`ifndef MISALIGN_TRAP_EN
  assign misalign_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_pc  <= RESET_PC;
      pend_v   <= 1'b0;
      imem.req <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else
`ifdef MISALIGN_TRAP_EN
    // the faulting target stays in pc so a debugger can see where the jump went
    if (redirect && |redirect_pc[1:0]) begin
      misalign_err <= 1'b1;
      state        <= HALTED;
      imem.req     <= 1'b0;
      pc           <= redirect_pc;
      pend_v       <= 1'b0;
    end else
`endif
    case (state)
      BOOT: begin
        if (redirect) pc <= tgt;
        state    <= RUN;
        imem.req <= 1'b1;
      end
      RUN: begin
        if (fire) begin
          pc     <= redirect ? tgt : pend_v ? pend_pc : pc + WIDTH'(STEP);
          pend_v <= 1'b0;
          if (halt) begin
            state    <= HALTED;
            imem.req <= 1'b0;
          end
        end else if (redirect) begin
          pend_pc <= tgt;
          pend_v  <= 1'b1;
        end
      end
      HALTED: begin
        if (redirect) pc <= tgt;
        if (!halt && !misalign_err) begin
          state    <= RUN;
          imem.req <= 1'b1;
        end
      end
      default: begin
        state    <= BOOT;
        imem.req <= 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed scenarios plus randomized run against a behavioural fetch model.
module tb_pc_fetch_stage;
  logic        clk = 0, rst_n = 0, redirect = 0, halt = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] pps_a, pps_b;
  logic        kill_a, kill_b, err_a, err_b;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  pc_fetch_stage_if #(.WIDTH(32)) ia ();
  pc_fetch_stage_if #(.WIDTH(32)) ib ();
  pc_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4)) u_a (
    .clk(clk), .rst_n(rst_n), .imem(ia.master), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .pc_plus_step(pps_a), .fetch_kill(kill_a), .misalign_err(err_a));
  pc_fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .STEP(4)) u_b (
    .clk(clk), .rst_n(rst_n), .imem(ib.master), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .pc_plus_step(pps_b), .fetch_kill(kill_b), .misalign_err(err_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; redirect = 0; halt = 0; redirect_pc = 0; ia.ready = 0; ib.ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0; ia.ready = 1; ib.ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", ia.req); end
    checks++; if (ia.addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ia.addr); end
    checks++; if (kill_a !== 1'b0) begin failures++; $display("FAIL reset_kill got=%0b exp=0", kill_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_a); end
    rst_n = 1;
    #1;
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL boot_req got=%0b exp=0", ia.req); end
    tick;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ia.req !== 1'b1) begin failures++; $display("FAIL seq_req[%0d] got=%0b exp=1", i, ia.req); end
      checks++; if (ia.addr !== 32'(i * 4)) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, ia.addr, 32'(i * 4)); end
      checks++; if (pps_a !== 32'(i * 4 + 4)) begin failures++; $display("FAIL seq_pps[%0d] got=%h exp=%h", i, pps_a, 32'(i * 4 + 4)); end
      tick;
    end
  endtask

  task automatic test_stall;
    tick;
    ia.ready = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ia.addr !== 32'h10) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=10", i, ia.addr); end
      checks++; if (ia.req !== 1'b1) begin failures++; $display("FAIL stall_req[%0d] got=%0b exp=1", i, ia.req); end
      tick;
    end
    ia.ready = 1;
    #1;
    checks++; if (kill_a !== 1'b0) begin failures++; $display("FAIL stall_kill got=%0b exp=0", kill_a); end
    tick;
    checks++; if (ia.addr !== 32'h14) begin failures++; $display("FAIL stall_next got=%h exp=14", ia.addr); end
  endtask

  task automatic test_redirect;
    do_reset;
    tick;
    ia.ready = 1;
    tick; tick;
    checks++; if (ia.addr !== 32'h8) begin failures++; $display("FAIL redir_pre got=%h exp=8", ia.addr); end
    redirect = 1; redirect_pc = 32'h200;
    #1;
    checks++; if (kill_a !== 1'b1) begin failures++; $display("FAIL redir_kill got=%0b exp=1", kill_a); end
    tick;
    redirect = 0;
    #1;
    checks++; if (ia.addr !== 32'h200) begin failures++; $display("FAIL redir_addr got=%h exp=200", ia.addr); end
    checks++; if (kill_a !== 1'b0) begin failures++; $display("FAIL redir_nokill got=%0b exp=0", kill_a); end
    ia.ready = 0; redirect = 1; redirect_pc = 32'h300;
    tick;
    redirect_pc = 32'h400;
    tick;
    redirect = 0;
    #1;
    checks++; if (ia.addr !== 32'h200) begin failures++; $display("FAIL pend_hold got=%h exp=200", ia.addr); end
    checks++; if (kill_a !== 1'b0) begin failures++; $display("FAIL pend_nokill got=%0b exp=0", kill_a); end
    tick;
    ia.ready = 1;
    #1;
    checks++; if (kill_a !== 1'b1) begin failures++; $display("FAIL pend_kill got=%0b exp=1", kill_a); end
    tick;
    checks++; if (ia.addr !== 32'h400) begin failures++; $display("FAIL pend_addr got=%h exp=400", ia.addr); end
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    do_reset;
    tick;
    ib.ready = 1;
    for (int i = 0; i < 3; i++) begin
      e = 32'hFFFF_FFF8 + 32'(i * 4);
      checks++; if (ib.addr !== e) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, ib.addr, e); end
      checks++; if (pps_b !== e + 32'd4) begin failures++; $display("FAIL wrap_pps[%0d] got=%h exp=%h", i, pps_b, e + 32'd4); end
      tick;
    end
  endtask

  task automatic test_halt;
    do_reset;
    tick;
    ia.ready = 0; halt = 1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ia.req !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] got=%0b exp=1", i, ia.req); end
      tick;
    end
    ia.ready = 1;
    tick;
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL halt_stop got=%0b exp=0", ia.req); end
    tick;
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL halt_idle got=%0b exp=0", ia.req); end
    halt = 0;
    tick;
    checks++; if (ia.req !== 1'b1) begin failures++; $display("FAIL halt_release got=%0b exp=1", ia.req); end
    checks++; if (ia.addr !== 32'h4) begin failures++; $display("FAIL halt_addr got=%h exp=4", ia.addr); end
  endtask

  task automatic test_misalign;
    do_reset;
    tick;
    ia.ready = 1; redirect = 1; redirect_pc = 32'h102;
    tick;
    redirect = 0;
`ifdef MISALIGN_TRAP_EN
    tick;
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL mis_err got=%0b exp=1", err_a); end
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL mis_req got=%0b exp=0", ia.req); end
`else
    checks++; if (ia.addr !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=100", ia.addr); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL mis_err got=%0b exp=0", err_a); end
`endif
  endtask

  task automatic test_reset_midstall;
    do_reset;
    tick;
    ia.ready = 1;
    tick; tick;
    ia.ready = 0;
    tick;
    #2;
    rst_n = 0;
    #1;
    checks++; if (ia.req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%0b exp=0", ia.req); end
    checks++; if (ia.addr !== 32'h0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0", ia.addr); end
  endtask

  task automatic test_random;
    logic        m_req, m_boot, m_pv, fire, ek;
    logic [31:0] m_pc, m_ppc;
    do_reset;
    m_req = 0; m_boot = 1; m_pv = 0; m_pc = 0; m_ppc = 0;
    for (int n = 0; n < 600; n++) begin
      ia.ready    = $urandom_range(0, 2) != 0;
      redirect    = $urandom_range(0, 4) == 0;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 11) == 0) halt = ~halt;
      #1;
      fire = m_req && ia.ready;
      ek   = fire && (redirect || m_pv);
      checks++; if (ia.req !== m_req) begin failures++; $display("FAIL rnd_req[%0d] got=%0b exp=%0b", n, ia.req, m_req); end
      checks++; if (ia.addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", n, ia.addr, m_pc); end
      checks++; if (pps_a !== m_pc + 32'd4) begin failures++; $display("FAIL rnd_pps[%0d] got=%h exp=%h", n, pps_a, m_pc + 32'd4); end
      checks++; if (kill_a !== ek) begin failures++; $display("FAIL rnd_kill[%0d] got=%0b exp=%0b", n, kill_a, ek); end
      checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rnd_err[%0d] got=%0b exp=0", n, err_a); end
      if (!m_req) begin
        if (redirect) m_pc = redirect_pc;
        if (m_boot || !halt) begin m_req = 1; m_boot = 0; end
      end else if (fire) begin
        m_pc = redirect ? redirect_pc : m_pv ? m_ppc : m_pc + 32'd4;
        m_pv = 0;
        if (halt) m_req = 0;
      end else if (redirect) begin
        m_pv = 1; m_ppc = redirect_pc;
      end
      @(posedge clk);
      #1;
    end
    redirect = 0; halt = 0;
  endtask

  initial begin
    ia.ready = 0; ib.ready = 0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_wrap;
    test_halt;
    test_misalign;
    test_reset_midstall;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
